nios_sd_loader_sd_spi_shifter: RTL



---
 rtl/nios_sd_loader_sd_spi_shifter_if.sv | 22 ++
 rtl/nios_sd_loader_sd_spi_shifter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/nios_sd_loader_sd_spi_shifter_if.sv
// Avalon-MM slave bus bundle for the SD SPI byte engine.
// The Nios II side is the master and the shifter is the slave.
`timescale 1ns/1ps

interface nios_sd_loader_sd_spi_shifter_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_sd_loader_sd_spi_shifter.sv
// SPI mode-0 byte engine for the Nios II SD loader: DATA/STATUS/CONTROL registers on Avalon-MM.
// Optional macro SD_SPI_IRQ_EN adds a registered irq output (done & irq_enable).
`timescale 1ns/1ps

module nios_sd_loader_sd_spi_shifter #(
  parameter logic [7:0] DEFAULT_DIV = 8'd63,
  parameter int         DATA_BITS   = 8
) (
  input  logic clk,
  input  logic reset_n,
  nios_sd_loader_sd_spi_shifter_if.slave avs,
  output logic sd_clk,
  output logic sd_cs_n,
  output logic sd_mosi,
  input  logic sd_miso
`ifdef SD_SPI_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

  logic [1:0] state;
  logic [7:0] phase;
  logic [7:0] div;
  logic [7:0] div_latched;
  logic [3:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx;
  logic       done;
  logic       overrun;
  logic       irq_enable;
  logic       busy;

  logic data_wr;
  logic data_rd;
  logic status_wr;
  logic ctrl_wr;
  logic start;
  logic phase_done;
  logic transfer_done;
  logic unused_wd;

  assign data_wr   = avs.chipselect & ~avs.write_n & (avs.address == 2'd0);
  assign data_rd   = avs.chipselect & ~avs.read_n  & (avs.address == 2'd0);
  assign status_wr = avs.chipselect & ~avs.write_n & (avs.address == 2'd1);
  assign ctrl_wr   = avs.chipselect & ~avs.write_n & (avs.address == 2'd2);

  assign busy          = (state != IDLE);
  assign start         = (state == IDLE) & data_wr;
  assign phase_done    = (phase == div_latched);
  assign transfer_done = (state == HIGH) & phase_done & (bit_cnt == LAST_BIT);
  assign unused_wd     = ^avs.writedata[31:16];

  // Each half period lasts div_latched+1 clocks; bits launch on the falling edge, sample on the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= 8'd0;
      div_latched <= DEFAULT_DIV;
      bit_cnt     <= 4'd0;
      tx_sr       <= 8'd0;
      rx          <= 8'h00;
      sd_clk      <= 1'b0;
      sd_mosi     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (data_wr) begin
            state       <= LOW;
            tx_sr       <= avs.writedata[7:0];
            sd_mosi     <= avs.writedata[7];
            div_latched <= div;
            phase       <= 8'd0;
            bit_cnt     <= 4'd0;
          end
        end
        LOW: begin
          if (phase_done) begin
            phase   <= 8'd0;
            sd_clk  <= 1'b1;
            rx      <= {rx[6:0], sd_miso};
            bit_cnt <= bit_cnt + 4'd1;
            state   <= HIGH;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            phase  <= 8'd0;
            sd_clk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state   <= IDLE;
              sd_mosi <= 1'b1;
            end else begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              sd_mosi <= tx_sr[6];
              state   <= LOW;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion outranks any same-cycle clear so a finished byte is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done       <= 1'b0;
      overrun    <= 1'b0;
      sd_cs_n    <= 1'b1;
      irq_enable <= 1'b0;
      div        <= DEFAULT_DIV;
    end else begin
      if (transfer_done)
        done <= 1'b1;
      else if (start || data_rd || (status_wr && avs.writedata[1]))
        done <= 1'b0;

      if (data_wr && busy)
        overrun <= 1'b1;
      else if (status_wr && avs.writedata[2])
        overrun <= 1'b0;

      if (ctrl_wr) begin
        sd_cs_n    <= avs.writedata[0];
        irq_enable <= avs.writedata[1];
        div        <= avs.writedata[15:8];
      end
    end
  end

`ifdef SD_SPI_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      irq <= 1'b0;
    else
      irq <= done & irq_enable;
  end
`endif

  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      2'd0: avs.readdata = {24'd0, rx};
      2'd1: avs.readdata = {29'd0, overrun, done, busy};
      2'd2: avs.readdata = {16'd0, div, 6'd0, irq_enable, sd_cs_n};
      default: avs.readdata = 32'd0;
    endcase
  end

endmodule
